// File: rtl/y_hist_acc.sv
// y_hist_acc: per-frame grey-level histogram with saturating bins, read out as one beat per bin after each frame.
// Ports: clk, rstb (async, active high) | i_hav/i_vav/data_in: grey pixel stream with active flags
//        o_bin_valid/o_bin_idx/o_bin_cnt: readout beat per bin | o_done: last beat | o_drop: frame skipped
module y_hist_acc #(
  parameter int DATA_WIDTH  = 8,
  parameter int WIDTH_IMAG  = 384,
  parameter int HEIGHT_IMAG = 512,
  parameter int CNT_W       = 18
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  i_hav,
  input  logic                  i_vav,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  o_bin_valid,
  output logic [DATA_WIDTH-1:0] o_bin_idx,
  output logic [CNT_W-1:0]      o_bin_cnt,
  output logic                  o_done,
  output logic                  o_drop
);
  localparam int NBIN = 1 << DATA_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2, DUMP = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] IDX_LAST = '1;
  // Frames larger than the counter range rely on bin saturation.
  if (WIDTH_IMAG * HEIGHT_IMAG > CNT_MAX) begin : g_frame_may_saturate
  end
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic                  vav_q, vav_d;
  logic                  live_q, live_d;
  logic                  s1_v_q, s1_v_d;
  logic [DATA_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [CNT_W-1:0]      s1_cnt_q, s1_cnt_d;
  logic [CNT_W-1:0]      bins_q [NBIN];
  logic [CNT_W-1:0]      bins_d [NBIN];
  logic                  rise, fall, accept, dump;
  logic [CNT_W-1:0]      rd;
  always_comb begin
    vav_d = i_vav;
    live_d = 1'b1;
    // live_q masks the first sample after reset so a vav already high never looks like a rising edge
    rise = live_q & i_vav & ~vav_q;
    fall = vav_q & ~i_vav;
    dump = state_q == DUMP;
    accept = i_hav & i_vav & ((state_q == ACCUM) | ((state_q == IDLE) & rise));
    // s1 holds the incremented count being written this cycle; forward it for a repeat of the same bin
    rd = (s1_v_q && s1_idx_q == data_in) ? s1_cnt_q : bins_q[data_in];
    s1_v_d = accept;
    s1_idx_d = data_in;
    s1_cnt_d = (rd == CNT_MAX) ? rd : rd + CNT_W'(1);
    state_d = state_q;
    idx_d = idx_q;
    if (state_q == IDLE && rise) state_d = ACCUM;
    if (state_q == ACCUM && fall) state_d = FLUSH;
    // idx_q doubles as the flush cycle counter, leaving it at 0 for the first dump beat
    if (state_q == FLUSH) begin
      idx_d = (idx_q == DATA_WIDTH'(1)) ? '0 : idx_q + DATA_WIDTH'(1);
      state_d = (idx_q == DATA_WIDTH'(1)) ? DUMP : FLUSH;
    end
    if (dump) begin
      idx_d = idx_q + DATA_WIDTH'(1);
      state_d = (idx_q == IDX_LAST) ? IDLE : DUMP;
    end
    bins_d = bins_q;
    if (s1_v_q) bins_d[s1_idx_q] = s1_cnt_q;
    if (dump) bins_d[idx_q] = '0;
    o_bin_valid = dump;
    o_bin_idx = dump ? idx_q : '0;
    o_bin_cnt = dump ? bins_q[idx_q] : '0;
    o_done = dump & (idx_q == IDX_LAST);
    o_drop = rise & ((state_q == FLUSH) | (state_q == DUMP));
  end
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= IDLE;
      idx_q <= '0;
      vav_q <= 1'b0;
      live_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_idx_q <= '0;
      s1_cnt_q <= '0;
      for (int i = 0; i < NBIN; i++) bins_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vav_q <= vav_d;
      live_q <= live_d;
      s1_v_q <= s1_v_d;
      s1_idx_q <= s1_idx_d;
      s1_cnt_q <= s1_cnt_d;
      bins_q <= bins_d;
    end
  end
endmodule

// File: tb/tb_y_hist_acc.sv
// tb_y_hist_acc: directed-vector bench for y_hist_acc with a hand-built expected histogram.
module tb_y_hist_acc;
  logic clk = 1'b0;
  logic rstb, i_hav, i_vav;
  logic [7:0] data_in;
  logic o_bin_valid, o_done, o_drop;
  logic [7:0] o_bin_idx;
  logic [17:0] o_bin_cnt;
  logic v4, done4, drop4;
  logic [7:0] idx4;
  logic [3:0] cnt4;
  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_drop = 0;
  int exp_cnt [256];
  int c4, v0, d0;
  y_hist_acc dut (
    .clk(clk), .rstb(rstb), .i_hav(i_hav), .i_vav(i_vav), .data_in(data_in),
    .o_bin_valid(o_bin_valid), .o_bin_idx(o_bin_idx), .o_bin_cnt(o_bin_cnt),
    .o_done(o_done), .o_drop(o_drop)
  );
  y_hist_acc #(.CNT_W(4)) dut4 (
    .clk(clk), .rstb(rstb), .i_hav(i_hav), .i_vav(i_vav), .data_in(data_in),
    .o_bin_valid(v4), .o_bin_idx(idx4), .o_bin_cnt(cnt4),
    .o_done(done4), .o_drop(drop4)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_valid <= n_valid + int'(o_bin_valid);
    n_drop <= n_drop + int'(o_drop);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic drive(input logic h, input logic v, input logic [7:0] d);
    i_hav = h;
    i_vav = v;
    data_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_exp();
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
  endtask
  task automatic frame(input int w, input int h, input bit ramp, input logic [7:0] val);
    int n = 0;
    logic [7:0] d;
    drive(1'b0, 1'b1, 8'h00);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        d = ramp ? n[7:0] : val;
        drive(1'b1, 1'b1, d);
        exp_cnt[d]++;
        n++;
      end
      drive(1'b0, 1'b1, 8'hAA);
      drive(1'b0, 1'b1, 8'h55);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask
  task automatic dump_check(input string tag, input int total);
    int waited = 0;
    int sum = 0;
    logic [9:0] bg, be;
    @(negedge clk);
    while (!o_bin_valid && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    check({tag, " flush_len"}, waited, 2);
    if (!o_bin_valid) return;
    for (int i = 0; i < 256; i++) begin
      bg = {o_bin_valid, o_bin_idx, o_done};
      be = {1'b1, 8'(i), i == 255};
      check($sformatf("%s beat%0d {valid,idx,done}", tag, i), bg, be);
      check($sformatf("%s bin%0d", tag, i), o_bin_cnt, exp_cnt[i]);
      sum += int'(o_bin_cnt);
      if (i == 3) c4 = int'(cnt4);
      @(negedge clk);
    end
    check({tag, " idle_after_dump"}, {o_bin_valid, o_bin_idx, o_bin_cnt, o_done}, 0);
    check({tag, " sum"}, sum, total);
  endtask
  initial begin
    rstb = 1'b1;
    i_hav = 1'b1;
    i_vav = 1'b1;
    data_in = 8'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_bin_valid, o_bin_idx, o_bin_cnt, o_done, o_drop}, 0);
    @(posedge clk);
    #1 rstb = 1'b0;
    v0 = n_valid;
    repeat (6) drive(1'b1, 1'b1, 8'd9);
    repeat (6) drive(1'b0, 1'b0, 8'd9);
    check("vav_high_at_reset_no_dump", n_valid - v0, 0);
    for (int i = 0; i < 8; i++) drive(i[0], 1'b0, 8'h63);
    clear_exp();
    frame(4, 2, 1'b0, 8'h10);
    dump_check("f4x2_0x10", 8);
    clear_exp();
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b1, 8'd7);
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b0, 1'b0, 8'd5);
    exp_cnt[5] = 4;
    exp_cnt[7] = 1;
    dump_check("stream_55575", 5);
    clear_exp();
    frame(96, 64, 1'b1, 8'h00);
    dump_check("ramp_96x64", 6144);
    clear_exp();
    frame(4, 2, 1'b0, 8'h40);
    d0 = n_drop;
    fork
      dump_check("drop_frame_a", 8);
      begin
        repeat (40) drive(1'b0, 1'b0, 8'h00);
        repeat (10) drive(1'b1, 1'b1, 8'h41);
        drive(1'b0, 1'b0, 8'h00);
      end
    join
    check("drop_pulse_count", n_drop - d0, 1);
    clear_exp();
    frame(2, 2, 1'b0, 8'h42);
    dump_check("after_drop", 4);
    clear_exp();
    drive(1'b0, 1'b1, 8'h00);
    repeat (5) drive(1'b1, 1'b1, 8'h30);
    rstb = 1'b1;
    i_vav = 1'b0;
    i_hav = 1'b0;
    @(negedge clk);
    check("reset_mid_accum_outputs", {o_bin_valid, o_bin_idx, o_bin_cnt, o_done, o_drop}, 0);
    v0 = n_valid;
    @(posedge clk);
    #1 rstb = 1'b0;
    repeat (20) drive(1'b0, 1'b0, 8'h00);
    check("reset_mid_accum_no_dump", n_valid - v0, 0);
    frame(4, 2, 1'b0, 8'h20);
    dump_check("after_reset", 8);
    clear_exp();
    frame(20, 1, 1'b0, 8'd3);
    dump_check("twenty_threes", 20);
    check("saturated_bin3_cnt_w4", c4, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
